// File: rtl/mem_dump_reader_if.sv
// Bus bundle for mem_dump_reader: the byte-wide read port into data memory
// and the 32-bit valid/ready word stream out. The master modport is the dump
// engine. The slave modport is the memory plus the word sink.
interface mem_dump_reader_if #(
   parameter int ADDR_W = 10
);
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_rdata;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_data;
   logic [ADDR_W-1:0] out_addr;

   modport master (
      output mem_rd_en,
      output mem_addr,
      input  mem_rdata,
      output out_valid,
      input  out_ready,
      output out_data,
      output out_addr
   );

   modport slave (
      input  mem_rd_en,
      input  mem_addr,
      output mem_rdata,
      input  out_valid,
      output out_ready,
      input  out_data,
      input  out_addr
   );
endinterface

// File: rtl/mem_dump_reader.sv
// mem_dump_reader: walks word_count consecutive 32-bit words of the byte-wide
// data memory, starting at base_addr. Each word is built little-endian from
// four single-byte reads and streamed out on a valid/ready port.
// Fetching one word never overlaps presenting the previous word.
// With out_ready held high, the word period is 6 cycles.
// Optional feature, macro MEM_DUMP_CHECKSUM_EN: adds a 'checksum' output that
// holds the wrapping 32-bit sum of all words accepted since the last start.
module mem_dump_reader #(
   parameter int ADDR_W = 10,
   parameter int CNT_W  = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic [CNT_W-1:0]    word_count,
   output logic                busy,
   output logic                done,
`ifdef MEM_DUMP_CHECKSUM_EN
   output logic [31:0]         checksum,
`endif
   mem_dump_reader_if.master   bus
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_COLLECT = 3'd2,
      ST_PRESENT = 3'd3,
      ST_FINISH  = 3'd4
   } state_t;

   state_t            state_r, state_s;
   logic [1:0]        fetch_cnt_r, fetch_cnt_s;
   logic [ADDR_W-1:0] word_addr_r, word_addr_s;
   logic [CNT_W-1:0]  words_left_r, words_left_s;
   logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
   logic              mem_rd_en_r;
   logic              rd_pend_r;
   logic [31:0]       data_r;
   logic              busy_r;
   logic              done_r;
   logic              out_valid_r;
   logic              start_ok_s;
   logic              accept_s;

   // Next-state logic and address walking, with abort overriding every non-idle transition.
   always_comb begin
      state_s      = state_r;
      fetch_cnt_s  = fetch_cnt_r;
      word_addr_s  = word_addr_r;
      words_left_s = words_left_r;
      mem_addr_s   = mem_addr_r;
      start_ok_s   = start && (state_r == ST_IDLE);
      accept_s     = out_valid_r && bus.out_ready && !abort;

      case (state_r)
         ST_IDLE: begin
            if (start_ok_s) begin
               if (word_count != {CNT_W{1'b0}}) begin
                  state_s      = ST_FETCH;
                  fetch_cnt_s  = 2'd0;
                  word_addr_s  = base_addr;
                  words_left_s = word_count;
                  mem_addr_s   = base_addr;
               end else begin
                  state_s = ST_FINISH;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_FETCH: begin
            if (fetch_cnt_r == 2'd3) begin
               state_s     = ST_COLLECT;
               fetch_cnt_s = 2'd0;
            end else begin
               fetch_cnt_s = fetch_cnt_r + 2'd1;
               mem_addr_s  = mem_addr_r + ADDR_W'(1);
            end
         end
         ST_COLLECT: begin
            state_s = ST_PRESENT;
         end
         ST_PRESENT: begin
            if (accept_s) begin
               words_left_s = words_left_r - CNT_W'(1);
               if (words_left_r == CNT_W'(1)) begin
                  state_s = ST_FINISH;
               end else begin
                  state_s     = ST_FETCH;
                  word_addr_s = word_addr_r + ADDR_W'(4);
                  mem_addr_s  = word_addr_r + ADDR_W'(4);
               end
            end else begin
               state_s = ST_PRESENT;
            end
         end
         ST_FINISH: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase

      if (abort && (state_r != ST_IDLE)) begin
         state_s = ST_IDLE;
      end else begin
         state_s = state_s;
      end
   end

   // State and datapath registers.
   // Outputs are registered decodes of the next state, so they are glitch-free.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r      <= ST_IDLE;
         fetch_cnt_r  <= 2'd0;
         word_addr_r  <= {ADDR_W{1'b0}};
         words_left_r <= {CNT_W{1'b0}};
         mem_addr_r   <= {ADDR_W{1'b0}};
         mem_rd_en_r  <= 1'b0;
         rd_pend_r    <= 1'b0;
         data_r       <= 32'h0000_0000;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         out_valid_r  <= 1'b0;
      end else begin
         state_r      <= state_s;
         fetch_cnt_r  <= fetch_cnt_s;
         word_addr_r  <= word_addr_s;
         words_left_r <= words_left_s;
         mem_addr_r   <= mem_addr_s;
         mem_rd_en_r  <= (state_s == ST_FETCH);
         busy_r       <= (state_s == ST_FETCH) || (state_s == ST_COLLECT) ||
                         (state_s == ST_PRESENT);
         done_r       <= (state_s == ST_FINISH);
         out_valid_r  <= (state_s == ST_PRESENT);
         // Read data arrives one cycle after its strobe.
         // Shifting in from the top leaves the lowest-address byte in [7:0] after four bytes.
         rd_pend_r    <= mem_rd_en_r;
         if (rd_pend_r) begin
            data_r <= {bus.mem_rdata, data_r[31:8]};
         end else begin
            data_r <= data_r;
         end
      end
   end

`ifdef MEM_DUMP_CHECKSUM_EN
   logic [31:0] checksum_r;

   // Running wrapping sum of accepted words: cleared on start, frozen by abort.
   always_ff @(posedge clk) begin
      if (!rst) begin
         checksum_r <= 32'h0000_0000;
      end else if (start_ok_s) begin
         checksum_r <= 32'h0000_0000;
      end else if (accept_s) begin
         checksum_r <= checksum_r + data_r;
      end else begin
         checksum_r <= checksum_r;
      end
   end

   assign checksum = checksum_r;
`endif

   assign busy          = busy_r;
   assign done          = done_r;
   assign bus.mem_rd_en = mem_rd_en_r;
   assign bus.mem_addr  = mem_addr_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = data_r;
   assign bus.out_addr  = word_addr_r;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Self-checking bench for mem_dump_reader.
// Directed dumps push their expected words into a scoreboard queue. A monitor
// pops from that queue and compares on every out handshake. Timing, read
// counts, address wrap, abort, reset and (when MEM_DUMP_CHECKSUM_EN is
// defined) checksum are checked inline.
module tb_mem_dump_reader;

   localparam int ADDR_W = 10;
   localparam int CNT_W  = 8;

   typedef struct packed {
      logic [31:0]       data;
      logic [ADDR_W-1:0] addr;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              abort;
   logic [ADDR_W-1:0] base_addr;
   logic [CNT_W-1:0]  word_count;
   logic              busy;
   logic              done;
`ifdef MEM_DUMP_CHECKSUM_EN
   logic [31:0]       checksum;
`endif

   mem_dump_reader_if #(.ADDR_W(ADDR_W)) bus ();

   mem_dump_reader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .base_addr  (base_addr),
      .word_count (word_count),
      .busy       (busy),
      .done       (done),
`ifdef MEM_DUMP_CHECKSUM_EN
      .checksum   (checksum),
`endif
      .bus        (bus)
   );

   always #5 clk = ~clk;

   logic [7:0]        mem [0:(1<<ADDR_W)-1];
   exp_t              exp_q[$];
   logic [ADDR_W-1:0] rd_log[$];
   int                rd_cnt   = 0;
   int                n_checks = 0;
   int                n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Memory model: one-cycle read latency.
   always @(posedge clk) begin
      if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
   end

   // Read strobe logger.
   always @(negedge clk) begin
      if (rst && bus.mem_rd_en) begin
         rd_cnt++;
         rd_log.push_back(bus.mem_addr);
      end
   end

   // Scoreboard monitor: compare each accepted word with the queue head.
   always @(negedge clk) begin
      if (rst && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_word", bus.out_data, 32'hXXXX_XXXX);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_data", bus.out_data, e.data);
            check("sb_addr", 32'(bus.out_addr), 32'(e.addr));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_dump(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] c);
      base_addr  = b;
      word_count = c;
      start      = 1'b1;
      step();
      start      = 1'b0;
   endtask

   // Counts posedges since start was raised; expected to return 6.
   task automatic wait_valid(output int cyc);
      cyc = 1;
      while (!bus.out_valid && cyc < 40) begin
         step();
         cyc++;
      end
   endtask

   task automatic wait_done();
      int cyc;
      cyc = 0;
      while (!done && cyc < 60) begin
         step();
         cyc++;
      end
   endtask

   initial begin
      int lat;
      int rd0;
      int no_done;
      int stable;

      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;
      mem[0]  = 8'h08; mem[1]  = 8'h01; mem[2]  = 8'h00; mem[3]  = 8'h01;
      for (int i = 16; i < 20; i++) mem[i] = 8'h01;
      mem[20] = 8'hAA; mem[21] = 8'hBB; mem[22] = 8'hCC; mem[23] = 8'hDD;
      mem[40] = 8'h11; mem[41] = 8'h22; mem[42] = 8'h33; mem[43] = 8'h44;
      mem[1022] = 8'h5A; mem[1023] = 8'hA5;
      for (int i = 48; i < 52; i++) mem[i] = 8'h01;
      for (int i = 52; i < 56; i++) mem[i] = 8'hFF;

      rst = 1'b0; start = 1'b0; abort = 1'b0;
      base_addr = '0; word_count = '0; bus.out_ready = 1'b0;
      step(); step(); step();

      // Reset state.
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      check("rst_out_data", bus.out_data, 32'd0);
      check("rst_out_addr", 32'(bus.out_addr), 32'd0);
`ifdef MEM_DUMP_CHECKSUM_EN
      check("rst_checksum", checksum, 32'd0);
`endif
      rst = 1'b1;
      step();

      // Single aligned word.
      bus.out_ready = 1'b1;
      exp_q.push_back('{data: 32'h0100_0108, addr: 10'd0});
      rd0 = rd_cnt;
      start_dump(10'd0, 8'd1);
      check("t1_busy", 32'(busy), 32'd1);
      wait_valid(lat);
      check("t1_latency", 32'(lat), 32'd6);
      step();
      check("t1_done", 32'(done), 32'd1);
      check("t1_busy_fin", 32'(busy), 32'd0);
      check("t1_reads", 32'(rd_cnt - rd0), 32'd4);
      step();
      check("t1_done_low", 32'(done), 32'd0);

      // Two back-to-back words.
      exp_q.push_back('{data: 32'h0101_0101, addr: 10'd16});
      exp_q.push_back('{data: 32'hDDCC_BBAA, addr: 10'd20});
      rd0 = rd_cnt;
      start_dump(10'd16, 8'd2);
      wait_valid(lat);
      check("t2_latency", 32'(lat), 32'd6);
      step();
      wait_valid(lat);
      check("t2_period", 32'(lat), 32'd6);
      step();
      check("t2_done", 32'(done), 32'd1);
      check("t2_reads", 32'(rd_cnt - rd0), 32'd8);
      step();

      // Backpressure.
      bus.out_ready = 1'b0;
      exp_q.push_back('{data: 32'h4433_2211, addr: 10'd40});
      start_dump(10'd40, 8'd1);
      wait_valid(lat);
      check("t3_latency", 32'(lat), 32'd6);
      rd0 = rd_cnt;
      stable = 1;
      for (int i = 0; i < 10; i++) begin
         step();
         if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h4433_2211) stable = 0;
      end
      check("t3_stable", 32'(stable), 32'd1);
      check("t3_no_reads", 32'(rd_cnt - rd0), 32'd0);
      bus.out_ready = 1'b1;
      step();
      check("t3_accepted", 32'(bus.out_valid), 32'd0);
      check("t3_done", 32'(done), 32'd1);
      step();

      // Address wrap.
      rd_log.delete();
      exp_q.push_back('{data: 32'h0108_A55A, addr: 10'd1022});
      start_dump(10'd1022, 8'd1);
      wait_valid(lat);
      check("t4_latency", 32'(lat), 32'd6);
      check("t4_nreads", 32'(rd_log.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check("t4_rd_addr", (i < rd_log.size()) ? 32'(rd_log[i]) : 32'hFFFF_FFFF,
               (i == 0) ? 32'd1022 : (i == 1) ? 32'd1023 : 32'(i - 2));
      end
      wait_done();
      check("t4_done", 32'(done), 32'd1);
      step();

      // Zero count.
      rd0 = rd_cnt;
      start_dump(10'd100, 8'd0);
      check("t5_zero_done", 32'(done), 32'd1);
      check("t5_zero_busy", 32'(busy), 32'd0);
      step();
      check("t5_zero_done_low", 32'(done), 32'd0);
      check("t5_zero_reads", 32'(rd_cnt - rd0), 32'd0);

      // Abort during the second fetch cycle.
      start_dump(10'd0, 8'd1);
      step();
      check("t6_fetch2_rd_en", 32'(bus.mem_rd_en), 32'd1);
      check("t6_fetch2_addr", 32'(bus.mem_addr), 32'd1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("t6_abort_busy", 32'(busy), 32'd0);
      check("t6_abort_rd_en", 32'(bus.mem_rd_en), 32'd0);
      check("t6_abort_valid", 32'(bus.out_valid), 32'd0);
      no_done = 1;
      for (int i = 0; i < 10; i++) begin
         if (done !== 1'b0 || bus.out_valid !== 1'b0) no_done = 0;
         step();
      end
      check("t6_no_done", 32'(no_done), 32'd1);

      // Reset while presenting, then a clean restart.
      bus.out_ready = 1'b0;
      start_dump(10'd16, 8'd1);
      wait_valid(lat);
      check("t7_valid", 32'(bus.out_valid), 32'd1);
      rst = 1'b0;
      step();
      check("t7_rst_valid", 32'(bus.out_valid), 32'd0);
      check("t7_rst_busy", 32'(busy), 32'd0);
      check("t7_rst_data", bus.out_data, 32'd0);
      check("t7_rst_addr", 32'(bus.out_addr), 32'd0);
      check("t7_rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      rst = 1'b1;
      bus.out_ready = 1'b1;
      step();
      exp_q.push_back('{data: 32'hDDCC_BBAA, addr: 10'd20});
      start_dump(10'd20, 8'd1);
      wait_valid(lat);
      check("t7_restart_latency", 32'(lat), 32'd6);
      step();
      check("t7_restart_done", 32'(done), 32'd1);
      step();

`ifdef MEM_DUMP_CHECKSUM_EN
      // Checksum over two words.
      exp_q.push_back('{data: 32'h0101_0101, addr: 10'd48});
      exp_q.push_back('{data: 32'hFFFF_FFFF, addr: 10'd52});
      start_dump(10'd48, 8'd2);
      wait_done();
      check("t8_done", 32'(done), 32'd1);
      check("t8_checksum", checksum, 32'h0101_0100);
      step();
      check("t8_checksum_hold", checksum, 32'h0101_0100);
`endif

      step();
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
